reg_bus_ctrl: RTL and testbench

- Transfer sequencer for the boosted register bank's shared 16-bit bus.
- Accepts register-to-register move commands (src, dst) through a valid/ready port and buffers them in a small FIFO.
- Executes each command as a two-phase bus transfer: it drives the bus source-select and output enable, then pulses the destination register's load enable.
- Sits between the control unit and the bus mux / register write enables.

---
 rtl/reg_bus_ctrl_if.sv | 27 ++
 rtl/reg_bus_ctrl.sv | 128 ++++++++++++
 tb/tb_reg_bus_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bus_ctrl_if.sv
// Command port and bus-control signals between the control unit (master)
// and the transfer sequencer (slave).
interface reg_bus_ctrl_if #(
  parameter int NREG  = 2,
  parameter int SEL_W = 1
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [SEL_W-1:0] cmd_src;
  logic [SEL_W-1:0] cmd_dst;
  logic [SEL_W-1:0] sel_bus;
  logic             bus_oe;
  logic [NREG-1:0]  load_en;
  logic             done;
  logic             err;
  logic             busy;

  modport master (
    output cmd_valid, cmd_src, cmd_dst,
    input  cmd_ready, sel_bus, bus_oe, load_en, done, err, busy
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst,
    output cmd_ready, sel_bus, bus_oe, load_en, done, err, busy
  );
endinterface

// File: rtl/reg_bus_ctrl.sv
// Register-bank bus transfer sequencer: buffers (src, dst) move commands in a
// circular FIFO and runs each as a DRIVE (bus settle) then LOAD (strobe) pair.
module reg_bus_ctrl #(
  parameter int NREG  = 2,
  parameter int SEL_W = 1,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  reg_bus_ctrl_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [2*SEL_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               head_seen_reg;
  logic [SEL_W-1:0]   cur_src_reg, cur_dst_reg;
  logic               err_reg;

  logic               accept, cmd_ok, push, pop;
  logic               load_phase;
  logic [(1<<SEL_W)-1:0] idx_ok;

  // Indices at or above NREG name no register and are rejected.
  for (genvar gi = 0; gi < (1 << SEL_W); gi++) begin : g_idx
    assign idx_ok[gi] = (gi < NREG);
  end

  assign bus.cmd_ready = (count_reg != CNT_W'(DEPTH));
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign cmd_ok        = idx_ok[bus.cmd_src] && idx_ok[bus.cmd_dst] &&
                         (bus.cmd_src != bus.cmd_dst);
  assign push          = accept && cmd_ok;

  // A freshly written entry sits one cycle before IDLE may pop it, giving the
  // two-cycle accept-to-DRIVE latency; LOAD chains straight into the next one.
  assign pop = (count_reg != '0) &&
               (((state_reg == ST_IDLE) && head_seen_reg) || (state_reg == ST_LOAD));

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {bus.cmd_src, bus.cmd_dst};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      head_seen_reg <= 1'b0;
      cur_src_reg   <= '0;
      cur_dst_reg   <= '0;
      err_reg       <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg                 <= rd_ptr_reg + 1'b1;
        {cur_src_reg, cur_dst_reg} <= fifo_mem[rd_ptr_reg];
      end
      count_reg     <= count_next;
      head_seen_reg <= (count_reg != '0);
      err_reg       <= accept && !cmd_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (pop) state_next = ST_DRIVE;
      ST_DRIVE: state_next = ST_LOAD;
      ST_LOAD:  state_next = pop ? ST_DRIVE : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // cur_src_reg only changes on a pop, so it also holds the select in IDLE.
  always_comb begin
    bus.sel_bus = cur_src_reg;
    bus.bus_oe  = 1'b0;
    bus.done    = 1'b0;
    bus.err     = err_reg;
    bus.busy    = (state_reg != ST_IDLE) || (count_reg != '0);
    load_phase  = 1'b0;
    case (state_reg)
      ST_DRIVE: bus.bus_oe = 1'b1;
      ST_LOAD: begin
        bus.bus_oe = 1'b1;
        bus.done   = 1'b1;
        load_phase = 1'b1;
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_load
    assign bus.load_en[gi] = load_phase && (cur_dst_reg == SEL_W'(gi));
  end
endmodule

// File: tb/tb_reg_bus_ctrl.sv
// Bench for reg_bus_ctrl: schedule-based reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_reg_bus_ctrl;
  localparam int NREG  = 2;
  localparam int SEL_W = 1;
  localparam int DEPTH = 4;
  localparam int HN    = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;

  reg_bus_ctrl_if #(.NREG(NREG), .SEL_W(SEL_W)) bus ();

  reg_bus_ctrl #(.NREG(NREG), .SEL_W(SEL_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // A transfer accepted at edge a is popped at edge d: DRIVE in cycle d,
  // LOAD in cycle d+1.
  typedef struct {
    int               a;
    int               d;
    logic [SEL_W-1:0] src;
    logic [SEL_W-1:0] dst;
  } xfer_t;

  xfer_t            q[$];
  int               last_load = -100;
  logic [SEL_W-1:0] sel_hold = '0;
  logic             exp_ready = 1'b1;
  logic             exp_err;
  int               cyc = 0;
  int               checks = 0;
  int               failures = 0;

  logic             oe_h   [HN];
  logic [NREG-1:0]  load_h [HN];
  logic             done_h [HN];
  logic             err_h  [HN];
  logic             busy_h [HN];
  logic             ready_h[HN];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge(input logic rs, input logic acc,
                            input logic [SEL_W-1:0] s, input logic [SEL_W-1:0] d);
    xfer_t x;
    exp_err = 1'b0;
    if (rs) begin
      q.delete();
      last_load = -100;
      sel_hold  = '0;
    end else if (acc) begin
      if (s == d || int'(s) >= NREG || int'(d) >= NREG) begin
        exp_err = 1'b1;
      end else begin
        x.a   = cyc;
        x.d   = (cyc <= last_load) ? last_load + 1 : cyc + 2;
        x.src = s;
        x.dst = d;
        last_load = x.d + 1;
        q.push_back(x);
      end
    end
  endtask

  task automatic compare();
    logic            e_oe, e_done, e_busy;
    logic [NREG-1:0] e_load;
    int              cnt;
    e_oe = 1'b0; e_done = 1'b0; e_load = '0; cnt = 0;
    foreach (q[i]) begin
      if (q[i].d == cyc) begin
        e_oe = 1'b1;
        sel_hold = q[i].src;
      end
      if (q[i].d + 1 == cyc) begin
        e_oe = 1'b1;
        e_done = 1'b1;
        e_load[q[i].dst] = 1'b1;
      end
      if (q[i].d > cyc) cnt++;
    end
    while (q.size() > 0 && q[0].d + 1 <= cyc) void'(q.pop_front());
    e_busy    = e_oe || (cnt != 0);
    exp_ready = (cnt != DEPTH);
    chk("cmd_ready", 32'(bus.cmd_ready), 32'(exp_ready));
    chk("sel_bus",   32'(bus.sel_bus),   32'(sel_hold));
    chk("bus_oe",    32'(bus.bus_oe),    32'(e_oe));
    chk("load_en",   32'(bus.load_en),   32'(e_load));
    chk("done",      32'(bus.done),      32'(e_done));
    chk("err",       32'(bus.err),       32'(exp_err));
    chk("busy",      32'(bus.busy),      32'(e_busy));
    if (cyc < HN) begin
      oe_h[cyc] = bus.bus_oe; load_h[cyc] = bus.load_en; done_h[cyc] = bus.done;
      err_h[cyc] = bus.err; busy_h[cyc] = bus.busy; ready_h[cyc] = bus.cmd_ready;
    end
  endtask

  task automatic step();
    logic acc, rs;
    logic [SEL_W-1:0] s, d;
    acc = bus.cmd_valid && exp_ready;
    rs  = rst;
    s   = bus.cmd_src;
    d   = bus.cmd_dst;
    @(posedge clk);
    #1;
    cyc++;
    model_edge(rs, acc, s, d);
    compare();
    $display("cycle=%0d rst=%0d acc=%0d src=%0d dst=%0d oe=%0d sel=%0d load=%b done=%0d err=%0d busy=%0d",
             cyc, rs, acc && !rs, s, d, bus.bus_oe, bus.sel_bus, bus.load_en, bus.done, bus.err, bus.busy);
  endtask

  task automatic idle(input int n);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [SEL_W-1:0] s, input logic [SEL_W-1:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_src   = s;
    bus.cmd_dst   = d;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    int r, a, b, n, cnt_done, sent, nd;
    logic ok, saw_full;
    bus.cmd_valid = 1'b0;
    bus.cmd_src   = '0;
    bus.cmd_dst   = '0;

    // Reset and single move accepted at edge r+5.
    rst = 1'b1;
    step();
    rst = 1'b0;
    r = cyc;
    chk("rst_ready", 32'(ready_h[r]), 32'd1);
    chk("rst_busy",  32'(busy_h[r]),  32'd0);
    chk("rst_oe",    32'(oe_h[r]),    32'd0);
    idle(4);
    send(1'b1, 1'b0);
    idle(6);
    chk("single_c7_oe",   32'(oe_h[r+7]),   32'd1);
    chk("single_c7_load", 32'(load_h[r+7]), 32'd0);
    chk("single_c8_load", 32'(load_h[r+8]), 32'b01);
    chk("single_c8_done", 32'(done_h[r+8]), 32'd1);
    chk("single_c9_oe",   32'(oe_h[r+9]),   32'd0);
    chk("single_c9_busy", 32'(busy_h[r+9]), 32'd0);

    // Back-to-back moves on consecutive edges.
    a = cyc + 1;
    send(1'b1, 1'b0);
    send(1'b0, 1'b1);
    send(1'b1, 1'b0);
    idle(10);
    chk("b2b_load1", 32'(load_h[a+3]), 32'b01);
    chk("b2b_load2", 32'(load_h[a+5]), 32'b10);
    chk("b2b_load3", 32'(load_h[a+7]), 32'b01);
    ok = 1'b1;
    for (int c = a + 2; c <= a + 7; c++) if (!oe_h[c]) ok = 1'b0;
    chk("b2b_oe_continuous", 32'(ok), 32'd1);
    cnt_done = 0;
    for (int c = a; c <= a + 10; c++) if (done_h[c]) cnt_done++;
    chk("b2b_done_count", 32'(cnt_done), 32'd3);

    // Full FIFO: hold valid until seven commands are taken.
    a = cyc + 1;
    sent = 0;
    saw_full = 1'b0;
    n = 0;
    while (sent < 7 && n < 100) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_src   = (sent % 2 == 0) ? 1'b1 : 1'b0;
      bus.cmd_dst   = (sent % 2 == 0) ? 1'b0 : 1'b1;
      if (exp_ready) sent++;
      step();
      if (!ready_h[cyc]) saw_full = 1'b1;
      n++;
    end
    chk("full_sent", 32'(sent), 32'd7);
    idle(24);
    chk("full_ready_dropped", 32'(saw_full), 32'd1);
    nd = 0;
    for (int c = a; c <= cyc; c++) begin
      if (done_h[c]) begin
        chk("full_order", 32'(load_h[c]), (nd % 2 == 0) ? 32'b01 : 32'b10);
        nd++;
      end
    end
    chk("full_done_count", 32'(nd), 32'd7);

    // Invalid command followed by a valid one.
    a = cyc + 1;
    send(1'b1, 1'b1);
    idle(6);
    chk("inv_err_pulse", 32'(err_h[a]),   32'd1);
    chk("inv_err_once",  32'(err_h[a+1]), 32'd0);
    chk("inv_busy",      32'(busy_h[a]),  32'd0);
    ok = 1'b1;
    for (int c = a; c <= a + 5; c++) if (oe_h[c] || load_h[c] != '0) ok = 1'b0;
    chk("inv_no_bus", 32'(ok), 32'd1);
    b = cyc + 1;
    send(1'b0, 1'b1);
    idle(5);
    chk("inv_next_load", 32'(load_h[b+3]), 32'b10);
    chk("inv_next_done", 32'(done_h[b+3]), 32'd1);

    // Reset during DRIVE with two commands still queued.
    send(1'b1, 1'b0);
    send(1'b0, 1'b1);
    send(1'b1, 1'b0);
    n = 0;
    while (!(bus.bus_oe && bus.load_en == '0) && n < 10) begin
      step();
      n++;
    end
    chk("rstmid_found_drive", 32'(n < 10), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_oe",    32'(oe_h[cyc]),    32'd0);
    chk("rstmid_load",  32'(load_h[cyc]),  32'd0);
    chk("rstmid_busy",  32'(busy_h[cyc]),  32'd0);
    chk("rstmid_ready", 32'(ready_h[cyc]), 32'd1);
    a = cyc;
    idle(10);
    cnt_done = 0;
    for (int c = a; c <= cyc; c++) if (done_h[c]) cnt_done++;
    chk("rstmid_no_done", 32'(cnt_done), 32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      bus.cmd_valid = ($urandom_range(0, 2) != 0);
      bus.cmd_src   = SEL_W'($urandom_range(0, (1 << SEL_W) - 1));
      bus.cmd_dst   = SEL_W'($urandom_range(0, (1 << SEL_W) - 1));
      step();
    end
    rst = 1'b0;
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
